// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_unit                                                    |
// | Purpose  : RV32 instruction-fetch front end. Sequential fetch over a     |
// |            valid/ready memory channel, DEPTH-entry in-order queue to     |
// |            decode, redirect flush with discard of in-flight responses.   |
// |            FETCH_BYPASS_EN: response forwarded to decode in same cycle.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req_valid,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_req_ready,
    input  logic                       imem_resp_valid,
    input  logic [31:0]                imem_resp_data,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [31:0]                deq_instr,
    output logic [XLEN-1:0]            deq_pc,
    output logic [XLEN-1:0]            deq_pc_plus_4,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int          OW      = $clog2(DEPTH+1);
    localparam logic [OW:0] DEPTH_W = (OW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   fill_ptr_q, fill_ptr_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic [OW-1:0]   pend_q, pend_d;
    logic [OW-1:0]   drop_q, drop_d;
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [31:0]     instr_q [DEPTH];

    logic [OW-1:0]   w_filled;
    logic [OW:0]     w_budget;
    logic            w_req_fire;
    logic            w_resp_drop;
    logic            w_resp_fill;
    logic            w_byp;
    logic            w_deq_fire;

    // Entries rd..fill-1 are filled, fill..wr-1 are pending (responses are in order).
    assign w_filled    = occ_q - pend_q;
    assign w_budget    = {1'b0, occ_q} + {1'b0, drop_q};
    assign w_resp_drop = imem_resp_valid && (drop_q != '0);
    assign w_resp_fill = imem_resp_valid && (drop_q == '0) && (pend_q != '0);

    assign imem_req_valid = rst && (w_budget < DEPTH_W) && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

`ifdef FETCH_BYPASS_EN
    assign w_byp     = (w_filled == '0) && w_resp_fill;
    assign deq_instr = w_byp ? imem_resp_data : instr_q[rd_ptr_q];
`else
    assign w_byp     = 1'b0;
    assign deq_instr = instr_q[rd_ptr_q];
`endif

    assign deq_valid     = ((w_filled != '0) || w_byp) && !redirect_valid;
    assign deq_pc        = pc_q[rd_ptr_q];
    assign deq_pc_plus_4 = deq_pc + XLEN'(4);
    assign w_deq_fire    = deq_valid && deq_ready;
    assign occupancy     = occ_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fill_ptr_d = fill_ptr_q;
        occ_d      = occ_q;
        pend_d     = pend_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            // Every pending entry turns into a response to discard, less one already arriving now.
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fill_ptr_d = '0;
            occ_d      = '0;
            pend_d     = '0;
            drop_d     = drop_q + pend_q - OW'(w_resp_drop || w_resp_fill);
        end else begin
            if (w_req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
                wr_ptr_d   = wr_ptr_q + AW'(1);
            end
            if (w_resp_drop) begin
                drop_d = drop_q - OW'(1);
            end
            if (w_resp_fill) begin
                fill_ptr_d = fill_ptr_q + AW'(1);
            end
            if (w_deq_fire) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            occ_d  = occ_q + OW'(w_req_fire) - OW'(w_deq_fire);
            pend_d = pend_q + OW'(w_req_fire) - OW'(w_resp_fill);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            occ_q      <= '0;
            pend_q     <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            occ_q      <= occ_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
        end
    end

    // Payload storage needs no reset: validity lives entirely in the counters.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            pc_q[wr_ptr_q] <= fetch_pc_q;
        end
        if (w_resp_fill && !redirect_valid) begin
            instr_q[fill_ptr_q] <= imem_resp_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fetch_unit                                                 |
// | Purpose  : Self-checking bench for fetch_unit with an in-order memory    |
// |            model and a stream-level reference of the decode interface.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;
    logic [31:0] deq_pc_plus_4;
    logic [2:0]  occupancy;

    fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .deq_valid       (deq_valid),
        .deq_ready       (deq_ready),
        .deq_instr       (deq_instr),
        .deq_pc          (deq_pc),
        .deq_pc_plus_4   (deq_pc_plus_4),
        .occupancy       (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mem_t;

    mem_t        mq[$];
    int          cyc, epoch, last_due, lat_min, lat_max;
    int          p_ready, p_deq;
    int          checks, errors;
    int          occ_m, filled_m;
    logic [31:0] exp_pc, exp_req;
    logic        bogus;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance model at posedge.
    task automatic run_cycle(input logic redir, input logic [31:0] rpc);
        logic resp_any, resp_cur, exp_rv, exp_dv, byp, req_fire, deq_fire;
        int   stale, d;
        imem_req_ready = ($urandom_range(99) < p_ready);
        deq_ready      = ($urandom_range(99) < p_deq);
        redirect_valid = redir;
        redirect_pc    = rpc;
        resp_any       = 1'b0;
        resp_cur       = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (bogus && mq.size() == 0) begin
            imem_resp_valid = 1'b1;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq[0].addr);
            resp_any        = 1'b1;
            resp_cur        = (mq[0].epoch == epoch);
        end
        @(negedge clk);
        stale = 0;
        foreach (mq[i]) if (mq[i].epoch != epoch) stale++;
        exp_rv = ((occ_m + stale) < DEPTH) && !redir;
        check("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) check("req_addr", imem_req_addr, exp_req);
        byp = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = (filled_m == 0) && resp_cur;
`endif
        exp_dv = ((filled_m > 0) || byp) && !redir;
        check("deq_valid", deq_valid, exp_dv);
        if (exp_dv) begin
            check("deq_pc", deq_pc, exp_pc);
            check("deq_pc_plus_4", deq_pc_plus_4, exp_pc + 32'd4);
            check("deq_instr", deq_instr, mem_word(exp_pc));
        end
        check("occupancy", occupancy, occ_m);
        req_fire = exp_rv && imem_req_ready;
        deq_fire = exp_dv && deq_ready;
        @(posedge clk);
        if (resp_any) void'(mq.pop_front());
        if (redir) begin
            epoch++;
            occ_m    = 0;
            filled_m = 0;
            exp_pc   = rpc & ~32'd3;
            exp_req  = rpc & ~32'd3;
        end else begin
            if (req_fire) begin
                d = cyc + $urandom_range(lat_max, lat_min);
                if (d <= last_due) d = last_due + 1;
                mq.push_back('{addr: exp_req, epoch: epoch, due: d});
                last_due = d;
                exp_req  = exp_req + 32'd4;
                occ_m++;
            end
            if (resp_cur) filled_m++;
            if (deq_fire) begin
                filled_m--;
                occ_m--;
                exp_pc = exp_pc + 32'd4;
            end
        end
        cyc++;
        bogus = 1'b0;
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) run_cycle(1'b0, 32'h0);
    endtask

    task automatic model_reset();
        mq.delete();
        epoch++;
        last_due = cyc;
        occ_m    = 0;
        filled_m = 0;
        exp_pc   = RESET_PC;
        exp_req  = RESET_PC;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; epoch = 0; last_due = 0;
        lat_min = 1; lat_max = 1; p_ready = 100; p_deq = 100; bogus = 1'b0;
        rst = 1'b0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; deq_ready = 1'b1;
        model_reset();

        // Reset state
        #1;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_deq_valid", deq_valid, 1'b0);
        check("rst_occupancy", occupancy, 3'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // Unsolicited response with nothing pending must be ignored
        p_ready = 0;
        bogus = 1'b1;
        run_cycle(1'b0, 32'h0);
        run(2);
        p_ready = 100;

        // Streaming, latency 1
        run(20);

        // Backpressure until full, then drain
        p_deq = 0;
        run(12);
        check("full_occupancy", occupancy, 3'd4);
        check("full_req_valid", imem_req_valid, 1'b0);
        p_deq = 100;
        run(10);

        // Redirect with three requests in flight
        lat_min = 3; lat_max = 3;
        run_cycle(1'b1, 32'h0000_0080);
        run(3);
        run_cycle(1'b1, 32'h0000_0200);
        run(14);

        // Redirect coinciding with a response for a pending entry
        lat_min = 2; lat_max = 2;
        run_cycle(1'b1, 32'h0000_0100);
        run(2);
        run_cycle(1'b1, 32'h0000_0300);
        run(10);

        // Back-to-back redirects, then address wrap with unaligned target
        run_cycle(1'b1, 32'h0000_0400);
        run_cycle(1'b1, 32'hFFFF_FFFB);
        run(12);

        // Randomized traffic
        lat_min = 1; lat_max = 4; p_ready = 70; p_deq = 70;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(99) < 4)
                run_cycle(1'b1, ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(31)))
                                                         : 32'($urandom));
            else
                run_cycle(1'b0, 32'h0);
        end

        // Asynchronous reset in mid-operation
        lat_min = 3; lat_max = 3; p_ready = 100; p_deq = 0;
        run_cycle(1'b1, 32'h0000_0800);
        run(5);
        #2;
        rst = 1'b0;
        #1;
        check("arst_req_valid", imem_req_valid, 1'b0);
        check("arst_deq_valid", deq_valid, 1'b0);
        check("arst_occupancy", occupancy, 3'd0);
        model_reset();
        imem_resp_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        cyc = cyc + 2;
        last_due = cyc;
        #1;
        rst = 1'b1;
        lat_min = 1; lat_max = 1; p_deq = 100;
        run(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the pipelined RV32 core. Replaces the single-register IF/ID path.
- Issues sequential instruction-memory requests over a valid/ready channel and accepts in-order responses with variable latency.
- Buffers up to DEPTH fetched instructions and presents them to decode with their PC and PC+4.
- Handles EX-stage redirects (jump/taken branch): flushes the queue and discards responses still in flight.

Parameters:
- XLEN, 32, width of PC and address.
- DEPTH, 4, queue entries; power of two, at least 2; also the bound on outstanding requests.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous reset, active-low (asserted when 0).
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  XLEN  fetch address, word aligned.
- imem_req_ready  input  1  memory accepts request.
- imem_resp_valid  input  1  response data valid; responses return in request order.
- imem_resp_data  input  32  instruction word.
- redirect_valid  input  1  EX-stage redirect (pc_src_e).
- redirect_pc  input  XLEN  redirect target (pc_target_e).
- deq_valid  output  1  instruction available to decode.
- deq_ready  input  1  decode accepts (driven as !stall_d).
- deq_instr  output  32  instruction word.
- deq_pc  output  XLEN  its PC.
- deq_pc_plus_4  output  XLEN  PC+4, wrapping modulo 2^XLEN.
- occupancy  output  $clog2(DEPTH+1)  allocated entries, both pending and filled.

Behaviour:
- **Reset:**
  - Asynchronous while rst=0: fetch_pc=RESET_PC.
  - Pointers, occupancy and drop_cnt are 0; all entries are invalid.
  - imem_req_valid=0 and deq_valid=0.
  - Outstanding memory transactions are lost; memory is reset with the same rst.
- **Entries:**
  - An entry is allocated at request handshake, holding pc and state pending.
  - It becomes filled when its response arrives.
  - Queue is a circular FIFO; rd and wr pointers wrap at DEPTH.
- **Request:**
  - imem_req_valid = (occupancy + drop_cnt < DEPTH) && !redirect_valid.
  - imem_req_addr = fetch_pc.
  - On handshake: allocate entry at wr_ptr, fetch_pc += 4 (wraps).
  - addr is stable while valid && !ready. The only exception is a redirect, which withdraws the request.
- **Response:**
  - If drop_cnt > 0: discard the data and decrement drop_cnt.
  - Otherwise fill the oldest pending entry.
  - A response with no pending entry and drop_cnt=0 is a protocol violation; it is ignored and must not corrupt state.
- **Dequeue:**
  - deq_valid = head entry filled && !redirect_valid.
  - deq_* come from the head entry, so response-to-deq latency is 1 cycle.
  - On deq_valid && deq_ready: free head and advance rd_ptr.
- **Simultaneous events, same cycle:**
  - Request handshake, response and dequeue may all occur. occupancy += request − dequeue.
  - A response may fill an entry that becomes head in the same cycle; it is visible on the next cycle.
- **Redirect** (redirect_valid=1, takes priority over everything):
  - No request is issued and no dequeue occurs.
  - All entries are invalidated; rd_ptr=wr_ptr=0; occupancy=0.
  - fetch_pc = redirect_pc with bits [1:0] forced to 0.
  - drop_cnt = drop_cnt + pending entries − (1 if a response arrives this cycle, whether it lands on a pending entry or on drop_cnt).
  - The first fetch from the new PC is issued the cycle after the redirect.
  - Back-to-back redirects are legal; the last one wins.
- **Full:** occupancy+drop_cnt == DEPTH holds the request low; no overflow is possible.
- **Empty:** deq_valid=0; downstream sees a bubble, which decode treats as a NOP.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- **Defined:**
  - When no filled entry exists ahead of the oldest pending one and imem_resp_valid=1 for it (drop_cnt=0, no redirect), deq_* are driven combinationally from imem_resp_data and that entry's pc.
  - If deq_ready=1 in that cycle, the entry is freed without being stored; response-to-deq latency is 0.
- **Undefined:** 1-cycle latency as above; deq_* are purely registered.

Test Plan:
- **Reset and stream:** release rst, memory ready=1, latency 1, deq_ready=1 → requests at 0x0,0x4,0x8,…; deq_pc 0x0,0x4,0x8 on consecutive cycles; deq_pc_plus_4=deq_pc+4; deq_instr matches memory.
- **Backpressure/full:** DEPTH=4, deq_ready=0 → exactly 4 request handshakes; then imem_req_valid=0 and occupancy=4. Raise deq_ready → entries drain in order 0x0..0xC, then fetch resumes at 0x10.
- **Redirect with in-flight:** latency 3, redirect_pc=0x200 while 3 requests are pending → those 3 responses are discarded. The first deq_pc after the redirect is 0x200 and no stale instruction ever has deq_valid=1.
- **Redirect with coincident response:** redirect in the same cycle as a response for a pending entry, with 2 pending → drop_cnt=1; next deq_pc=target.
- **Wrap:** redirect_pc=0xFFFF_FFF8 → deq_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; deq_pc_plus_4 of 0xFFFF_FFFC is 0x0.
- **Async reset mid-operation:** rst=0 with 2 pending and 2 filled → outputs clear immediately, not at a clock edge. After release, the first request is RESET_PC; with FETCH_BYPASS_EN, latency-1 memory gives deq_valid in the response cycle.
